// File: rtl/seven_seg_pkg.sv
// Shared types and hex decode for the seven-segment scan controller.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    AddrValue  = 2'd0,
    AddrDigen  = 2'd1,
    AddrDpmask = 2'd2,
    AddrCtrl   = 2'd3
  } reg_addr_e;

  typedef enum logic [1:0] {
    ScanIdle  = 2'd0,
    ScanBlank = 2'd1,
    ScanDrive = 2'd2
  } scan_state_e;

  localparam logic [1:0] StIdle  = ScanIdle;
  localparam logic [1:0] StBlank = ScanBlank;
  localparam logic [1:0] StDrive = ScanDrive;

  // Segment order {a,b,c,d,e,f,g}; 0 = lit.
  typedef logic [6:0] segments_t;

  function automatic segments_t hex_to_seg(input logic [3:0] nib);
    segments_t seg;
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_slot_timer.sv
// Slot sequencer: blank/drive timing, digit index and frame-boundary tick.
module seven_seg_slot_timer
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int unsigned CntW = $clog2(REFRESH_DIV)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            enable_i,
  output logic [1:0]      state_nxt_o,
  output logic [IdxW-1:0] idx_nxt_o,
  output logic            frame_tick_o
);

  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] DriveLast = CntW'(REFRESH_DIV - BLANK_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            frame_tick;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    frame_tick = 1'b0;
    if (!enable_i) begin
      state_d = StIdle;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        StBlank: begin
          if (cnt_q == BlankLast) begin
            state_d = StDrive;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StDrive: begin
          if (cnt_q == DriveLast) begin
            state_d = StBlank;
            cnt_d   = '0;
            if (idx_q == IdxLast) begin
              idx_d      = '0;
              frame_tick = 1'b1;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          // Leaving idle always starts a fresh frame at digit 0.
          state_d    = StBlank;
          cnt_d      = '0;
          idx_d      = '0;
          frame_tick = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  assign state_nxt_o  = state_d;
  assign idx_nxt_o    = idx_d;
  assign frame_tick_o = frame_tick;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment driver with shadow registers copied at frame boundaries.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_en_i,
  input  logic [1:0]            wr_addr_i,
  input  logic [31:0]           wr_data_i,
  input  logic [1:0]            rd_addr_i,
  output logic [31:0]           rd_data_o,
  output logic                  ca_o,
  output logic                  cb_o,
  output logic                  cc_o,
  output logic                  cd_o,
  output logic                  ce_o,
  output logic                  cf_o,
  output logic                  cg_o,
  output logic                  dp_o,
  output logic [NUM_DIGITS-1:0] anode_o,
  output logic                  frame_o
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [31:0]           value_q, active_value_q;
  logic [NUM_DIGITS-1:0] digen_q, dpmask_q, active_digen_q, active_dpmask_q;
  logic                  enable_q, enable_d, pending_q, pending_d;
  logic                  wr_value, wr_digen, wr_dpmask, wr_ctrl;
  logic [31:0]           rd_data_d, rd_data_q;
  logic [1:0]            state_nxt;
  logic [IdxW-1:0]       idx_nxt;
  logic                  frame_tick, frame_q;
  logic [NUM_DIGITS-1:0] anode_d, anode_q;
  segments_t             seg_d, seg_q;
  logic                  dp_d, dp_q;

  assign wr_value  = wr_en_i && (wr_addr_i == AddrValue);
  assign wr_digen  = wr_en_i && (wr_addr_i == AddrDigen);
  assign wr_dpmask = wr_en_i && (wr_addr_i == AddrDpmask);
  assign wr_ctrl   = wr_en_i && (wr_addr_i == AddrCtrl);

  // The timer sees the incoming enable so a CTRL write acts on its own edge.
  assign enable_d = wr_ctrl ? wr_data_i[0] : enable_q;

  always_comb begin
    pending_d = pending_q;
    if (wr_value || wr_digen || wr_dpmask) begin
      pending_d = 1'b1;
    end else if (frame_tick) begin
      pending_d = 1'b0;
    end
  end

  seven_seg_slot_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_slot_timer (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .enable_i    (enable_d),
    .state_nxt_o (state_nxt),
    .idx_nxt_o   (idx_nxt),
    .frame_tick_o(frame_tick)
  );

  always_comb begin
    case (rd_addr_i)
      AddrValue:  rd_data_d = value_q;
      AddrDigen:  rd_data_d = 32'(digen_q);
      AddrDpmask: rd_data_d = 32'(dpmask_q);
      default:    rd_data_d = {30'b0, pending_q, enable_q};
    endcase
  end

  // Active registers only change on copy edges, where the next state is blank.
  always_comb begin
    anode_d = '1;
    seg_d   = '1;
    dp_d    = 1'b1;
    if (state_nxt == StDrive) begin
      seg_d = hex_to_seg(active_value_q[4*idx_nxt +: 4]);
      dp_d  = ~active_dpmask_q[idx_nxt];
      if (active_digen_q[idx_nxt]) begin
        anode_d[idx_nxt] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      value_q         <= '0;
      digen_q         <= '1;
      dpmask_q        <= '0;
      enable_q        <= 1'b0;
      pending_q       <= 1'b0;
      active_value_q  <= '0;
      active_digen_q  <= '1;
      active_dpmask_q <= '0;
      rd_data_q       <= '0;
      frame_q         <= 1'b0;
      anode_q         <= '1;
      seg_q           <= '1;
      dp_q            <= 1'b1;
    end else begin
      if (frame_tick) begin
        active_value_q  <= value_q;
        active_digen_q  <= digen_q;
        active_dpmask_q <= dpmask_q;
      end
      if (wr_value)  value_q  <= wr_data_i;
      if (wr_digen)  digen_q  <= wr_data_i[NUM_DIGITS-1:0];
      if (wr_dpmask) dpmask_q <= wr_data_i[NUM_DIGITS-1:0];
      enable_q  <= enable_d;
      pending_q <= pending_d;
      rd_data_q <= rd_data_d;
      frame_q   <= frame_tick;
      anode_q   <= anode_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign frame_o   = frame_q;
  assign anode_o   = anode_q;
  assign {ca_o, cb_o, cc_o, cd_o, ce_o, cf_o, cg_o} = seg_q;
  assign dp_o      = dp_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with an 8-cycle slot and 2-cycle blank.
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = 2'd0;
  logic [31:0] wr_data = 32'd0;
  logic [1:0]  rd_addr = 2'd0;
  logic [31:0] rd_data;
  logic        ca, cb, cc, cd, ce, cf, cg, dp;
  logic [7:0]  anode;
  logic        frame;
  logic [6:0]  seg;

  int checks = 0;
  int failures = 0;
  int now = 0;

  assign seg = {ca, cb, cc, cd, ce, cf, cg};

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (8),
    .REFRESH_DIV (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data),
    .ca_o     (ca),
    .cb_o     (cb),
    .cc_o     (cc),
    .cd_o     (cd),
    .ce_o     (ce),
    .cf_o     (cf),
    .cg_o     (cg),
    .dp_o     (dp),
    .anode_o  (anode),
    .frame_o  (frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    now++;
  endtask

  task automatic run_to(input int t);
    while (now < t) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    rd_addr = a;
    tick();
    check(tag, rd_data, exp);
  endtask

  task automatic check_out(input string tag, input logic [7:0] exp_anode,
                           input logic [6:0] exp_seg, input logic exp_dp);
    check({tag, "_anode"}, 32'(anode), 32'(exp_anode));
    check({tag, "_seg"}, 32'(seg), 32'(exp_seg));
    check({tag, "_dp"}, 32'(dp), 32'(exp_dp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick();
    tick();
    check_out("in_reset", 8'hFF, 7'h7F, 1'b1);
    check("in_reset_frame", 32'(frame), 32'd0);
    rst_n = 1'b1;
    rd_check("rst_value", 2'd0, 32'h0);
    rd_check("rst_digen", 2'd1, 32'hFF);
    rd_check("rst_dpmask", 2'd2, 32'h0);
    rd_check("rst_ctrl", 2'd3, 32'h0);
    check_out("idle", 8'hFF, 7'h7F, 1'b1);
    check("idle_frame", 32'(frame), 32'd0);

    // First frame of 0x89ABCDEF; slot s blanks at 8s..8s+1, drives 8s+2..8s+7.
    wr(2'd0, 32'h89AB_CDEF);
    wr(2'd3, 32'h1);
    now = 0;
    check("start_frame", 32'(frame), 32'd1);
    check_out("start_blank", 8'hFF, 7'h7F, 1'b1);
    tick();
    check("start_frame_drop", 32'(frame), 32'd0);
    check_out("blank1", 8'hFF, 7'h7F, 1'b1);
    run_to(2);
    check_out("d0_F", 8'hFE, 7'b0111000, 1'b1);
    run_to(7);
    check_out("d0_F_end", 8'hFE, 7'b0111000, 1'b1);
    run_to(8);
    check_out("d1_blank", 8'hFF, 7'h7F, 1'b1);
    run_to(10);
    check_out("d1_E", 8'hFD, 7'b0110000, 1'b1);

    wr(2'd0, 32'h1111_1111);
    rd_check("ctrl_pending", 2'd3, 32'h3);
    run_to(58);
    check_out("d7_8_old", 8'h7F, 7'b0000000, 1'b1);
    run_to(64);
    check("wrap1_frame", 32'(frame), 32'd1);
    rd_check("ctrl_cleared", 2'd3, 32'h1);
    run_to(66);
    check_out("f2_d0_1", 8'hFE, 7'b1001111, 1'b1);

    wr(2'd1, 32'hFD);
    wr(2'd2, 32'h01);
    run_to(128);
    check("wrap2_frame", 32'(frame), 32'd1);
    run_to(130);
    check_out("f3_d0_dp", 8'hFE, 7'b1001111, 1'b0);
    run_to(138);
    check_out("f3_d1_off", 8'hFF, 7'b1001111, 1'b1);
    run_to(143);
    check("f3_d1_off_end", 32'(anode), 32'hFF);
    run_to(146);
    check("f3_d2_on", 32'(anode), 32'hFB);

    // Write lands on the same edge as the frame copy at 192.
    run_to(191);
    wr(2'd0, 32'h2222_2222);
    check("wrap3_frame", 32'(frame), 32'd1);
    rd_check("ctrl_boundary", 2'd3, 32'h3);
    run_to(194);
    check_out("f4_d0_old", 8'hFE, 7'b1001111, 1'b0);
    run_to(256);
    check("wrap4_frame", 32'(frame), 32'd1);
    rd_check("ctrl_wrap4", 2'd3, 32'h1);
    run_to(258);
    check_out("f5_d0_2", 8'hFE, 7'b0010010, 1'b0);

    wr(2'd3, 32'h0);
    check_out("disabled", 8'hFF, 7'h7F, 1'b1);
    rd_check("ctrl_off", 2'd3, 32'h0);
    check_out("disabled2", 8'hFF, 7'h7F, 1'b1);

    wr(2'd3, 32'h1);
    now = 0;
    check("reen_frame", 32'(frame), 32'd1);
    check("reen_blank", 32'(anode), 32'hFF);
    run_to(2);
    check_out("reen_d0", 8'hFE, 7'b0010010, 1'b0);

    // Asynchronous reset in the low phase, no clock edge in between.
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 8'hFF, 7'h7F, 1'b1);
    check("async_rst_frame", 32'(frame), 32'd0);
    check("async_rst_rd", rd_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_check("post_rst_value", 2'd0, 32'h0);
    rd_check("post_rst_digen", 2'd1, 32'hFF);
    rd_check("post_rst_ctrl", 2'd3, 32'h0);
    check_out("post_rst_idle", 8'hFF, 7'h7F, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
